// File: rtl/ahb_sync_mem_bridge.sv
// AHB-Lite slave in front of a synchronous byte-writable memory. Reads go out in the
// address phase. A write that collides with a read is held in a one-entry buffer.
module ahb_sync_mem_bridge #(
  parameter int unsigned L2DEP = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hsel,
  input  logic [L2DEP+1:0]     haddr,
  input  logic [1:0]           htrans,
  input  logic                 hwrite,
  input  logic [2:0]           hsize,
  input  logic                 hready,
  input  logic [31:0]          hwdata,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [L2DEP-1:0]     mem_address,
  output logic [3:0]           mem_wstrobe,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [1:0] {StOkay, StErr1, StErr2} resp_state_e;

  resp_state_e state_q, state_d;

  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic             dp_err_q, dp_err_d;
  logic [L2DEP-1:0] dp_addr_q, dp_addr_d;
  logic [3:0]       dp_strb_q, dp_strb_d;

  logic             buf_valid_q, buf_valid_d;
  logic [L2DEP-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]       buf_strb_q, buf_strb_d;
  logic [31:0]      buf_data_q, buf_data_d;

  logic       accept, illegal, rd_issue, rd_dp, wr_dp;
  logic       wr_direct, buf_load, buf_flush, fwd_hit;
  logic [3:0] strb;
  logic       unused_htrans;

  assign unused_htrans = htrans[0];

  always_comb begin
    illegal = 1'b0;
    strb    = 4'b0000;
    case (hsize)
      3'd0: strb = 4'b0001 << haddr[1:0];
      3'd1: begin
        illegal = haddr[0];
        strb    = haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        illegal = (haddr[1:0] != 2'b00);
        strb    = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    accept    = hsel & htrans[1] & hready;
    rd_issue  = accept & ~hwrite & ~illegal;
    rd_dp     = dp_valid_q & ~dp_write_q & ~dp_err_q;
    wr_dp     = dp_valid_q & dp_write_q & ~dp_err_q;
    // A write data phase only loses the port to a read; the buffer drains on the next free cycle.
    wr_direct = wr_dp & ~rd_issue;
    buf_load  = wr_dp & rd_issue;
    buf_flush = buf_valid_q & ~rd_issue & ~wr_direct;
    fwd_hit   = buf_valid_q & (buf_addr_q == dp_addr_q);
  end

  always_comb begin
    dp_valid_d = accept;
    dp_write_d = dp_write_q;
    dp_err_d   = dp_err_q;
    dp_addr_d  = dp_addr_q;
    dp_strb_d  = dp_strb_q;
    if (accept) begin
      dp_write_d = hwrite;
      dp_err_d   = illegal;
      dp_addr_d  = haddr[L2DEP+1:2];
      dp_strb_d  = strb;
    end

    buf_valid_d = buf_load | (buf_valid_q & ~buf_flush);
    buf_addr_d  = buf_addr_q;
    buf_strb_d  = buf_strb_q;
    buf_data_d  = buf_data_q;
    if (buf_load) begin
      buf_addr_d = dp_addr_q;
      buf_strb_d = dp_strb_q;
      buf_data_d = hwdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOkay:  if (accept && illegal) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = (accept && illegal) ? StErr1 : StOkay;
      default: state_d = StOkay;
    endcase
  end

  always_comb begin
    hreadyout   = reset | (state_q != StErr1);
    hresp       = ~reset & (state_q != StOkay);
    mem_read    = ~reset & rd_issue;
    mem_write   = ~reset & (wr_direct | buf_flush);
    mem_address = rd_issue ? haddr[L2DEP+1:2] : (wr_direct ? dp_addr_q : buf_addr_q);
    mem_wstrobe = 4'b0000;
    if (!reset && wr_direct) mem_wstrobe = dp_strb_q;
    else if (!reset && buf_flush) mem_wstrobe = buf_strb_q;
    mem_wdata = wr_direct ? hwdata : buf_data_q;
    hrdata    = 32'h0;
    if (!reset && rd_dp) begin
      for (int b = 0; b < 4; b++) begin
        hrdata[8*b +: 8] = (fwd_hit && buf_strb_q[b]) ? buf_data_q[8*b +: 8]
                                                       : mem_rdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StOkay;
      dp_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_valid_q  <= dp_valid_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    dp_write_q <= dp_write_d;
    dp_err_q   <= dp_err_d;
    dp_addr_q  <= dp_addr_d;
    dp_strb_q  <= dp_strb_d;
    buf_addr_q <= buf_addr_d;
    buf_strb_q <= buf_strb_d;
    buf_data_q <= buf_data_d;
  end

endmodule
